// File: rtl/db15_joy_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// db15_joy_scanner: two-pad DB15 scanner for a 32-bit 74HC165 chain; define DB15_DEBOUNCE_EN for frame-agreement filtering. Rev 1.0
// ----------------------------------------------------------------------------
module db15_joy_scanner #(
  parameter int CLK_DIV = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        ld_q, ld_d;
  logic        jclk_q, jclk_d;
  logic        jload_q, jload_d;
  logic [31:0] raw_q, raw_d;
  logic [15:0] j1_q, j1_d;
  logic [15:0] j2_q, j2_d;
  logic [1:0]  sync_q;
  logic        w_tick;

`ifdef DB15_DEBOUNCE_EN
  logic [31:0] prev_q, prev_d;
`endif

  assign w_tick     = (div_q == C_DIV_LAST);
  assign div_d      = w_tick ? 8'd0 : div_q + 8'd1;
  assign joy_clk    = jclk_q;
  assign joy_load   = jload_q;
  assign joystick1  = j1_q;
  assign joystick2  = j2_q;
  assign frame_done = (state_q == ST_LATCH);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ld_d    = ld_q;
    jclk_d  = jclk_q;
    jload_d = jload_q;
    raw_d   = raw_q;
    j1_d    = j1_q;
    j2_d    = j2_q;
`ifdef DB15_DEBOUNCE_EN
    prev_d  = prev_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (w_tick) begin
          if (!ld_q) begin
            ld_d    = 1'b1;
            jload_d = 1'b0;
            jclk_d  = 1'b1;
          end else begin
            ld_d    = 1'b0;
            jload_d = 1'b1;
            bit_d   = 5'd0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (jclk_q) begin
            jclk_d = 1'b0;
          end else begin
            // Capture the current bit before the rising edge advances the chain.
            jclk_d       = 1'b1;
            raw_d[bit_q] = sync_q[1];
            bit_d        = bit_q + 5'd1;
            if (bit_q == 5'd31) state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        state_d = ST_LOAD;
`ifdef DB15_DEBOUNCE_EN
        prev_d = raw_q;
        if (raw_q == prev_q) begin
          j1_d = ~raw_q[15:0];
          j2_d = ~raw_q[31:16];
        end
`else
        j1_d = ~raw_q[15:0];
        j2_d = ~raw_q[31:16];
`endif
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      ld_q    <= 1'b0;
      jclk_q  <= 1'b1;
      jload_q <= 1'b1;
      raw_q   <= '1;
      j1_q    <= '0;
      j2_q    <= '0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ld_q    <= ld_d;
      jclk_q  <= jclk_d;
      jload_q <= jload_d;
      raw_q   <= raw_d;
      j1_q    <= j1_d;
      j2_q    <= j2_d;
      sync_q  <= {sync_q[0], joy_data};
    end
  end

`ifdef DB15_DEBOUNCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '1;
    else       prev_q <= prev_d;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_db15_joy_scanner.sv
`default_nettype none
// Scoreboard bench for db15_joy_scanner: a 74HC165 chain model feeds random pad words,
// expected joystick words are queued at each parallel load and checked at frame_done.
module tb_db15_joy_scanner;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_CLKS = 66 * CLK_DIV;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic        frame_done;
  logic [15:0] joystick1;
  logic [15:0] joystick2;

  int checks = 0;
  int errors = 0;

  db15_joy_scanner #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_data   (joy_data),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // External shift-register chain: word bit k is the k-th bit presented after a load.
  logic [31:0] sr     = '1;
  logic [31:0] last_w = '1;
  logic [31:0] m_prev = '1;
  logic [15:0] m_j1   = '0;
  logic [15:0] m_j2   = '0;
  logic [31:0] dir_q[$];
  logic [31:0] exp_q[$];

  assign joy_data = sr[0];

  always @(negedge joy_load) begin
    logic [31:0] w;
    if (dir_q.size() > 0)             w = dir_q.pop_front();
    else if ($urandom_range(0, 2) == 0) w = last_w;
    else                              w = $urandom;
    last_w = w;
    sr     = w;
`ifdef DB15_DEBOUNCE_EN
    if (w == m_prev) begin
      m_j1 = ~w[15:0];
      m_j2 = ~w[31:16];
    end
    m_prev = w;
`else
    m_j1 = ~w[15:0];
    m_j2 = ~w[31:16];
`endif
    exp_q.push_back({m_j2, m_j1});
  end

  always @(posedge joy_clk) begin
    if (joy_load === 1'b1) sr = {1'b1, sr[31:1]};
  end

  // Monitor state
  logic [15:0] held1 = '0;
  logic [15:0] held2 = '0;
  bit          pending     = 1'b0;
  bit          first_frame = 1'b1;
  bit          prev_jclk   = 1'b1;
  int          n_rise = 0, n_load_low = 0, n_clk_low = 0, n_period = 0;
  int          frames = 0;

  always @(posedge reset) begin
    exp_q.delete();
    m_prev      = '1;
    m_j1        = '0;
    m_j2        = '0;
    held1       = '0;
    held2       = '0;
    pending     = 1'b0;
    first_frame = 1'b1;
    prev_jclk   = 1'b1;
    n_rise      = 0;
    n_load_low  = 0;
    n_clk_low   = 0;
    n_period    = 0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (pending) begin
        chk("joystick1 after latch", {16'd0, joystick1}, {16'd0, held1});
        chk("joystick2 after latch", {16'd0, joystick2}, {16'd0, held2});
        chk("frame_done one clk", {31'd0, frame_done}, 32'd0);
        pending = 1'b0;
      end
      n_period++;
      if (!joy_load) n_load_low++;
      if (!joy_clk) n_clk_low++;
      if (joy_clk && !prev_jclk) n_rise++;
      prev_jclk = joy_clk;
      if (frame_done) begin
        chk("joystick1 hold", {16'd0, joystick1}, {16'd0, held1});
        chk("joystick2 hold", {16'd0, joystick2}, {16'd0, held2});
        chk("joy_clk rises per frame", n_rise, 32);
        chk("joy_load low clks", n_load_low, CLK_DIV);
        chk("joy_clk low clks", n_clk_low, 32 * CLK_DIV);
        if (!first_frame) chk("frame period", n_period, FRAME_CLKS);
        chk("scoreboard entry present", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          logic [31:0] e;
          e       = exp_q.pop_front();
          held1   = e[15:0];
          held2   = e[31:16];
          pending = 1'b1;
        end
        n_rise      = 0;
        n_load_low  = 0;
        n_clk_low   = 0;
        n_period    = 0;
        first_frame = 1'b0;
        frames++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " joy_clk"}, {31'd0, joy_clk}, 32'd1);
    chk({tag, " joy_load"}, {31'd0, joy_load}, 32'd1);
    chk({tag, " joystick1"}, {16'd0, joystick1}, 32'd0);
    chk({tag, " joystick2"}, {16'd0, joystick2}, 32'd0);
    chk({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  task automatic first_latency(input string name);
    int n = 0;
    for (int i = 1; i <= FRAME_CLKS + 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        n = i;
        break;
      end
    end
    chk(name, n, FRAME_CLKS);
  endtask

  task automatic wait_frames(input int target);
    int guard = 0;
    while (frames < target && guard < (target + 2) * FRAME_CLKS) begin
      @(posedge clk);
      guard++;
    end
    chk("frames reached", {31'd0, frames >= target}, 32'd1);
  endtask

  initial begin
    dir_q.push_back(32'hFFFF_FFFE);
    dir_q.push_back(32'h7FFF_FFFF);
    dir_q.push_back(32'hFFFF_FFEF);
    dir_q.push_back(32'hFFFF_FFFB);
    dir_q.push_back(32'hFFFF_FFFB);

    #2 reset = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    first_latency("first frame latency");
    wait_frames(12);

    // Land inside bit 17 of the next frame, then reset.
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
        @(posedge clk);
        #1;
        if (frame_done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("frame_done before mid-frame reset", {31'd0, seen}, 32'd1);
    end
    repeat (37 * CLK_DIV) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid-frame reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    first_latency("latency after mid-frame reset");
    wait_frames(frames + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
